// File: rtl/riscv_i32_ifetch_responder.sv
// riscv_i32_ifetch_responder: answers i32 instruction fetches from a synchronous SRAM with optional wait states
module riscv_i32_ifetch_responder #(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS_LOG2 = 14,
  parameter logic [2:0] DEBUG_MODE = 3'h7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ifetch_req__valid,
  input  logic [31:0]               ifetch_req__address,
  input  logic                      ifetch_req__sequential,
  input  logic [2:0]                ifetch_req__mode,
  input  logic                      ifetch_req__flush,
  output logic                      ifetch_resp__valid,
  output logic                      ifetch_resp__debug,
  output logic [31:0]               ifetch_resp__data,
  output logic [2:0]                ifetch_resp__mode,
  output logic                      ifetch_resp__error,
  output logic [1:0]                ifetch_resp__tag,
  output logic                      sram_read,
  output logic [MEM_WORDS_LOG2-1:0] sram_address,
  input  logic [31:0]               sram_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  state_t state, state_nxt;
  logic [2:0] count, count_nxt, mode;
  logic [1:0] tag;
  logic error, bad, flush, done, accept, unused;
  assign unused = ifetch_req__sequential;
  always_comb begin
    bad = (|ifetch_req__address[1:0]) | (|ifetch_req__address[31:MEM_WORDS_LOG2+2]);
    flush = ~reset & ifetch_req__valid & ifetch_req__flush;
    done = state == BUSY && count == 3'd0;
    accept = ~reset & ifetch_req__valid & (state == IDLE || done || ifetch_req__flush);
    state_nxt = accept ? BUSY : done ? IDLE : state;
    count_nxt = accept ? (bad ? 3'd0 : WS) : count != 3'd0 ? count - 3'd1 : count;
    // a flush in the answering cycle discards the word that was about to be returned
    ifetch_resp__valid = done & ~flush;
    ifetch_resp__data = ifetch_resp__valid && !error ? sram_rdata : 32'd0;
    ifetch_resp__mode = ifetch_resp__valid ? mode : 3'd0;
    ifetch_resp__error = ifetch_resp__valid & error;
    ifetch_resp__debug = ifetch_resp__valid && mode == DEBUG_MODE;
    ifetch_resp__tag = ifetch_resp__valid ? tag : 2'd0;
    sram_read = accept & ~bad;
    sram_address = sram_read ? ifetch_req__address[MEM_WORDS_LOG2+1:2] : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 3'd0;
      tag <= 2'd0;
      mode <= 3'd0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tag <= flush ? 2'd0 : ifetch_resp__valid ? tag + 2'd1 : tag;
      if (accept) begin
        mode <= ifetch_req__mode;
        error <= bad;
      end
    end
  end
endmodule

// File: tb/tb_riscv_i32_ifetch_responder.sv
// tb_riscv_i32_ifetch_responder: checks a zero-wait and a two-wait responder against a due-cycle model
module tb_riscv_i32_ifetch_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rst = '1, valid = '0, seq = '0, flush = '0, rv, rdbg, rerr, sread;
  logic [31:0] addr[2] = '{32'd0, 32'd0};
  logic [31:0] rdata[2];
  logic [31:0] srdata[2] = '{32'd0, 32'd0};
  logic [2:0] mode[2] = '{3'd0, 3'd0};
  logic [2:0] rmode[2];
  logic [1:0] rtag[2];
  logic [13:0] saddr[2];
  int checks = 0, passes = 0;
  const int ws[2] = '{0, 2};
  bit pv[2] = '{0, 0};
  bit perr[2];
  int pdue[2], ntag[2] = '{0, 0}, nresp[2] = '{0, 0}, t0[2];
  logic [31:0] paddr[2];
  logic [2:0] pmode[2];
  int lr_cyc[2], lr_tag[2];
  logic [31:0] lr_data[2];
  logic lr_err[2], lr_dbg[2], rd_seen[2];
  logic [2:0] lr_mode[2];
  logic [13:0] ad_seen[2];

  riscv_i32_ifetch_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst[0]), .ifetch_req__valid(valid[0]), .ifetch_req__address(addr[0]),
    .ifetch_req__sequential(seq[0]), .ifetch_req__mode(mode[0]), .ifetch_req__flush(flush[0]),
    .ifetch_resp__valid(rv[0]), .ifetch_resp__debug(rdbg[0]), .ifetch_resp__data(rdata[0]),
    .ifetch_resp__mode(rmode[0]), .ifetch_resp__error(rerr[0]), .ifetch_resp__tag(rtag[0]),
    .sram_read(sread[0]), .sram_address(saddr[0]), .sram_rdata(srdata[0]));
  riscv_i32_ifetch_responder #(.WAIT_STATES(2)) u2 (
    .clk(clk), .reset(rst[1]), .ifetch_req__valid(valid[1]), .ifetch_req__address(addr[1]),
    .ifetch_req__sequential(seq[1]), .ifetch_req__mode(mode[1]), .ifetch_req__flush(flush[1]),
    .ifetch_resp__valid(rv[1]), .ifetch_resp__debug(rdbg[1]), .ifetch_resp__data(rdata[1]),
    .ifetch_resp__mode(rmode[1]), .ifetch_resp__error(rerr[1]), .ifetch_resp__tag(rtag[1]),
    .sram_read(sread[1]), .sram_address(saddr[1]), .sram_rdata(srdata[1]));

  function automatic logic [31:0] memf(logic [13:0] w);
    return 32'hC0DE_0000 | {18'd0, w};
  endfunction

  task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL u%0d %s: got %0h, expected %0h (cycle %0d)", inst, nm, act, exp, cyc);
  endtask

  always @(posedge clk)
    for (int i = 0; i < 2; i++) if (sread[i]) srdata[i] <= memf(saddr[i]);

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit due, fl, acc, ev, e;
      e = addr[i][1:0] != 2'd0 || addr[i][31:16] != 16'd0;
      due = !rst[i] && pv[i] && cyc == pdue[i];
      fl = !rst[i] && valid[i] && flush[i];
      ev = due && !fl;
      acc = !rst[i] && valid[i] && (!pv[i] || due || flush[i]);
      chk(i, "resp_valid", rv[i], ev);
      chk(i, "resp_data", rdata[i], ev && !perr[i] ? memf(paddr[i][15:2]) : 32'd0);
      chk(i, "resp_mode", rmode[i], ev ? pmode[i] : 3'd0);
      chk(i, "resp_debug", rdbg[i], ev && pmode[i] == 3'd7);
      chk(i, "resp_error", rerr[i], ev && perr[i]);
      chk(i, "resp_tag", rtag[i], ev ? 2'(ntag[i]) : 2'd0);
      chk(i, "sram_read", sread[i], acc && !e);
      chk(i, "sram_address", saddr[i], acc && !e ? addr[i][15:2] : 14'd0);
      if (rv[i]) begin
        nresp[i]++;
        lr_cyc[i] = cyc; lr_data[i] = rdata[i]; lr_tag[i] = int'(rtag[i]);
        lr_err[i] = rerr[i]; lr_dbg[i] = rdbg[i]; lr_mode[i] = rmode[i];
      end
      if (rst[i]) begin
        pv[i] = 0; ntag[i] = 0;
      end else begin
        if (ev) ntag[i]++;
        if (fl) ntag[i] = 0;
        if (due) pv[i] = 0;
        if (acc) begin
          pv[i] = 1; pdue[i] = cyc + 1 + (e ? 0 : ws[i]);
          paddr[i] = addr[i]; pmode[i] = mode[i]; perr[i] = e;
        end
      end
    end
  end

  task automatic wait_resp(input int i);
    @(posedge clk); #1 flush[i] = 0;
    #1;
    for (int k = 0; k < 12 && !rv[i]; k++) begin @(posedge clk); #2; end
    if (!rv[i]) chk(i, "resp_timeout", rv[i], 1);
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [2:0] m, input bit f);
    valid[i] = 1; addr[i] = a; mode[i] = m; flush[i] = f; t0[i] = cyc;
    #1 rd_seen[i] = sread[i]; ad_seen[i] = saddr[i];
    wait_resp(i);
  endtask

  task automatic idle(input int i, input int n);
    valid[i] = 0; flush[i] = 0; seq[i] = 0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #100000 $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = '0;
    issue(0, 32'h10, 3'd0, 0);
    chk(0, "t1_sram_read", rd_seen[0], 1);
    chk(0, "t1_sram_address", ad_seen[0], 14'd4);
    idle(0, 2);
    chk(0, "t1_latency", lr_cyc[0] - t0[0], 1);
    chk(0, "t1_data", lr_data[0], 32'hC0DE_0004);
    chk(0, "t1_tag", lr_tag[0], 0);
    n = nresp[0]; t0[1] = cyc;
    issue(0, 32'h0, 3'd0, 1);
    n = n; seq[0] = 1;
    issue(0, 32'h4, 3'd0, 0);
    issue(0, 32'h8, 3'd0, 0);
    idle(0, 3);
    chk(0, "t2_count", nresp[0] - n, 3);
    chk(0, "t2_tag", lr_tag[0], 2);
    chk(0, "t2_data", lr_data[0], 32'hC0DE_0002);
    issue(0, 32'h2, 3'd1, 0);
    chk(0, "t4_misaligned_read", rd_seen[0], 0);
    idle(0, 1);
    chk(0, "t4_misaligned_error", lr_err[0], 1);
    chk(0, "t4_misaligned_data", lr_data[0], 0);
    issue(0, 32'h0010_0000, 3'd2, 0);
    chk(0, "t4_range_read", rd_seen[0], 0);
    idle(0, 1);
    chk(0, "t4_range_error", lr_err[0], 1);
    chk(0, "t4_range_latency", lr_cyc[0] - t0[0], 1);
    issue(0, 32'h3C, 3'd7, 0);
    idle(0, 1);
    chk(0, "t6_debug", lr_dbg[0], 1);
    chk(0, "t6_mode", lr_mode[0], 3'd7);
    chk(0, "t6_data", lr_data[0], 32'hC0DE_000F);
    issue(0, 32'h100, 3'd1, 1);
    seq[0] = 1;
    for (int k = 1; k < 6; k++) issue(0, 32'h100 + 32'(4 * k), 3'(k), 0);
    idle(0, 2);
    chk(0, "wrap_tag", lr_tag[0], 1);
    chk(0, "wrap_data", lr_data[0], 32'hC0DE_0045);

    issue(1, 32'h20, 3'd3, 0);
    idle(1, 1);
    chk(1, "t3_latency", lr_cyc[1] - t0[1], 3);
    chk(1, "t3_data", lr_data[1], 32'hC0DE_0008);
    issue(1, 32'h24, 3'd3, 0);
    issue(1, 32'h28, 3'd4, 0);
    idle(1, 1);
    chk(1, "b2b_latency", lr_cyc[1] - t0[1], 3);
    chk(1, "b2b_tag", lr_tag[1], 2);
    issue(1, 32'h1, 3'd0, 0);
    idle(1, 1);
    chk(1, "err_latency", lr_cyc[1] - t0[1], 1);
    chk(1, "err_flag", lr_err[1], 1);
    n = nresp[1]; t0[1] = cyc;
    valid[1] = 1; addr[1] = 32'h0; mode[1] = 3'd2;
    repeat (2) begin @(posedge clk); #2; end
    addr[1] = 32'h40; flush[1] = 1;
    wait_resp(1);
    idle(1, 2);
    chk(1, "t5_count", nresp[1] - n, 1);
    chk(1, "t5_latency", lr_cyc[1] - t0[1], 5);
    chk(1, "t5_data", lr_data[1], 32'hC0DE_0010);
    chk(1, "t5_tag", lr_tag[1], 0);
    n = nresp[1];
    valid[1] = 1; addr[1] = 32'h30; mode[1] = 3'd7;
    repeat (3) begin @(posedge clk); #2; end
    chk(1, "t6_due_valid", rv[1], 1);
    rst[1] = 1; valid[1] = 0;
    #1;
    chk(1, "t6_reset_valid", rv[1], 0);
    chk(1, "t6_reset_debug", rdbg[1], 0);
    chk(1, "t6_reset_data", rdata[1], 0);
    @(posedge clk); #2 rst[1] = 0;
    idle(1, 5);
    chk(1, "t6_no_resp", nresp[1] - n, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
